// File: rtl/complete_graph_transfer_sequencer.sv
// Request FIFO plus transfer FSM for the 16-port complete-graph channel netlist.
// Define FLUSH_PHASE_EN to add a dst-only drain phase between OPEN and DONE.
module complete_graph_transfer_sequencer #(
    parameter int unsigned N_PORTS      = 16,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned HOLD_CYCLES  = 8,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [IDX_W-1:0]   req_src_i,
    input  logic [IDX_W-1:0]   req_dst_i,
    output logic [N_PORTS-1:0] port_open_o,
    output logic [N_PORTS-1:0] port_dir_o,
    output logic               busy_o,
    output logic               done_pulse_o,
    output logic               err_pulse_o
);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W   = AW + 1;
    localparam int unsigned MAX_CYC = (HOLD_CYCLES > FLUSH_CYCLES) ? HOLD_CYCLES : FLUSH_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    typedef struct packed {
        logic [IDX_W-1:0] src;
        logic [IDX_W-1:0] dst;
    } xfer_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_OPEN,
`ifdef FLUSH_PHASE_EN
        S_FLUSH,
`endif
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   src_q;
    logic [IDX_W-1:0]   dst_q;
    logic [N_PORTS-1:0] open_q;
    logic [N_PORTS-1:0] dir_q;
    logic               done_q;
    logic               busy_q;
    logic               err_q;
    logic               ready_q;

    xfer_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic               empty_w;
    logic               accept_w;
    logic               bad_w;
    logic               push_w;
    logic               pop_w;
    xfer_t              head_w;

    function automatic logic [N_PORTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_PORTS'(1) << idx;
    endfunction

    assign empty_w  = (wr_ptr_q == rd_ptr_q);
    assign accept_w = req_valid_i && ready_q;
    assign head_w   = mem_q[rd_ptr_q[AW-1:0]];

    // Rejected requests still complete the handshake but never reach the FIFO.
    always_comb begin
        bad_w    = (req_src_i == req_dst_i)
                || ((IDX_W+1)'(req_src_i) >= (IDX_W+1)'(N_PORTS))
                || ((IDX_W+1)'(req_dst_i) >= (IDX_W+1)'(N_PORTS));
        push_w   = accept_w && !bad_w;
        pop_w    = ((state_q == S_IDLE) || (state_q == S_DONE)) && !empty_w;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_w);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_w);
    end

    always_ff @(posedge clk_i) begin
        if (push_w) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {req_src_i, req_dst_i};
        end
    end

    // Ready is precomputed from the next pointers so it is a pure register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ((wr_ptr_d - rd_ptr_d) != PTR_W'(FIFO_DEPTH));
            err_q    <= accept_w && bad_w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            open_q  <= '0;
            dir_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pop_w) begin
                        state_q <= S_SETUP;
                        src_q   <= head_w.src;
                        dst_q   <= head_w.dst;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= push_w;
                    end
                end
                S_SETUP: begin
                    state_q <= S_OPEN;
                    cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
                    open_q  <= onehot(src_q) | onehot(dst_q);
                    dir_q   <= onehot(src_q);
                end
                S_OPEN: begin
                    if (cnt_q == '0) begin
`ifdef FLUSH_PHASE_EN
                        state_q <= S_FLUSH;
                        cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
                        open_q  <= onehot(dst_q);
                        dir_q   <= '0;
`else
                        state_q <= S_DONE;
                        open_q  <= '0;
                        dir_q   <= '0;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
`ifdef FLUSH_PHASE_EN
                S_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                        open_q  <= '0;
                        dir_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
`endif
                S_DONE: begin
                    if (pop_w) begin
                        state_q <= S_SETUP;
                        src_q   <= head_w.src;
                        dst_q   <= head_w.dst;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= push_w;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign port_open_o  = open_q;
    assign port_dir_o   = dir_q;
    assign busy_o       = busy_q;
    assign done_pulse_o = done_q;
    assign err_pulse_o  = err_q;

endmodule

// File: tb/tb_complete_graph_transfer_sequencer.sv
// Scoreboard bench for complete_graph_transfer_sequencer; honours FLUSH_PHASE_EN when defined.
module tb_complete_graph_transfer_sequencer;
    localparam int HOLD = 8;
`ifdef FLUSH_PHASE_EN
    localparam int FLUSH = 4;
`else
    localparam int FLUSH = 0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_src;
    logic [3:0]  req_dst;
    logic [15:0] port_open;
    logic [15:0] port_dir;
    logic        busy;
    logic        done_pulse;
    logic        err_pulse;

    typedef struct {
        bit          is_err;
        logic [15:0] open;
        logic [15:0] dir;
        logic [15:0] fmask;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    complete_graph_transfer_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_src_i    (req_src),
        .req_dst_i    (req_dst),
        .port_open_o  (port_open),
        .port_dir_o   (port_dir),
        .busy_o       (busy),
        .done_pulse_o (done_pulse),
        .err_pulse_o  (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_xfer(input logic [15:0] o, input logic [15:0] d,
                               input logic [15:0] f, input int gap);
        exp_t e;
        e.is_err = 1'b0;
        e.open   = o;
        e.dir    = d;
`ifdef FLUSH_PHASE_EN
        e.fmask  = f;
`else
        e.fmask  = (f & 16'h0000);
`endif
        e.gap    = gap;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.open   = '0;
        e.dir    = '0;
        e.fmask  = '0;
        e.gap    = 0;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge, valid still high.
    task automatic hold_push(input logic [3:0] s, input logic [3:0] d, output bit stalled);
        int t;
        t = 0;
        stalled = 1'b0;
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
        while (!req_ready && t < 100) begin
            stalled = 1'b1;
            @(negedge clk);
            t++;
        end
        chk("ready_timeout", 32'(t < 100), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] s, input logic [3:0] d);
        bit st;
        hold_push(s, d, st);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", 32'(t < max_cyc), 32'd1);
        @(negedge clk);
    endtask

    // Monitor: tracks each open/flush run and scores it against the queue on done/err.
    logic [15:0] prev_open = '0;
    logic [15:0] run_open = '0, run_dir = '0, run_fmask = '0;
    int          open_len = 0, flush_len = 0, mon_cyc = 0, last_done = 0, open_start = 0;
    bit          run_ok = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        mon_cyc++;
        if (port_open != 16'h0) begin
            if (prev_open == 16'h0) begin
                run_open   = port_open;
                run_dir    = port_dir;
                run_fmask  = '0;
                open_len   = 0;
                flush_len  = 0;
                run_ok     = 1'b1;
                open_start = mon_cyc;
            end
            if (port_dir != 16'h0) begin
                open_len++;
                if (port_open != run_open || port_dir != run_dir || flush_len != 0) run_ok = 1'b0;
            end else begin
                if (flush_len == 0) run_fmask = port_open;
                else if (port_open != run_fmask) run_ok = 1'b0;
                flush_len++;
            end
        end
        if (err_pulse === 1'b1) begin
            chk("err_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("err_kind", 32'(e.is_err), 32'd1);
            end
        end
        if (done_pulse === 1'b1) begin
            chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("done_kind", 32'(e.is_err), 32'd0);
                chk("open_mask", 32'(run_open), 32'(e.open));
                chk("dir_mask", 32'(run_dir), 32'(e.dir));
                chk("open_len", 32'(open_len), 32'(HOLD));
                chk("flush_len", 32'(flush_len), 32'(FLUSH));
                chk("flush_mask", 32'(run_fmask), 32'(e.fmask));
                chk("phase_stable", 32'(run_ok), 32'd1);
                chk("done_open_zero", 32'(port_open), 32'd0);
                if (e.gap != 0) chk("setup_gap", 32'(open_start - last_done), 32'(e.gap));
            end
            last_done = mon_cyc;
        end
        prev_open = port_open;
    end

    initial begin
        bit st;
        int first_stall;
        int t;
        int n_done;
        int n_busy;
        logic [3:0]  bs [6] = '{4'd0, 4'd7, 4'd10, 4'd14, 4'd2, 4'd12};
        logic [3:0]  bd [6] = '{4'd15, 4'd4, 4'd11, 4'd6, 4'd13, 4'd8};
        logic [15:0] bo [6] = '{16'h8001, 16'h0090, 16'h0C00, 16'h4040, 16'h2004, 16'h1100};
        logic [15:0] bq [6] = '{16'h0001, 16'h0080, 16'h0400, 16'h4000, 16'h0004, 16'h1000};
        logic [15:0] bf [6] = '{16'h8000, 16'h0010, 16'h0800, 16'h0040, 16'h2000, 16'h0100};

        rst = 1'b1;
        req_valid = 1'b0;
        req_src = '0;
        req_dst = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_open", 32'(port_open), 32'd0);
        chk("rst_dir", 32'(port_dir), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_pulse), 32'd0);
        chk("rst_err", 32'(err_pulse), 32'd0);

        // Single transfer 3->9, cycle-exact timing from the accepting edge.
        expect_xfer(16'h0208, 16'h0008, 16'h0200, 0);
        send(4'd3, 4'd9);
        chk("t1_busy_accept", 32'(busy), 32'd1);
        chk("t1_setup_prev", 32'(port_open), 32'd0);
        for (int k = 1; k <= 11 + FLUSH; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 9) begin
                chk($sformatf("t1_open_c%0d", k), 32'(port_open), 32'h0208);
                chk($sformatf("t1_dir_c%0d", k), 32'(port_dir), 32'h0008);
            end
`ifdef FLUSH_PHASE_EN
            else if (k >= 10 && k <= 9 + FLUSH) begin
                chk($sformatf("t1_fopen_c%0d", k), 32'(port_open), 32'h0200);
                chk($sformatf("t1_fdir_c%0d", k), 32'(port_dir), 32'h0000);
            end
`endif
            else begin
                chk($sformatf("t1_open_c%0d", k), 32'(port_open), 32'h0000);
                chk($sformatf("t1_dir_c%0d", k), 32'(port_dir), 32'h0000);
            end
            chk($sformatf("t1_done_c%0d", k), 32'(done_pulse), 32'(k == 10 + FLUSH));
            chk($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(k < 11 + FLUSH));
        end

        // Rejected requests: same index twice.
        expect_err();
        send(4'd5, 4'd5);
        chk("t2_err", 32'(err_pulse), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t2_err_once", 32'(err_pulse), 32'd0);
        chk("t2_open", 32'(port_open), 32'd0);
        chk("t2_busy_after", 32'(busy), 32'd0);
        expect_err();
        send(4'd15, 4'd15);
        chk("t2b_err", 32'(err_pulse), 32'd1);
        repeat (3) @(negedge clk);
        chk("t2b_open", 32'(port_open), 32'd0);
        chk("t2b_busy", 32'(busy), 32'd0);

        // Back-to-back burst of six while a transfer is running.
        expect_xfer(16'h0006, 16'h0002, 16'h0004, 0);
        send(4'd1, 4'd2);
        repeat (3) @(negedge clk);
        first_stall = -1;
        for (int i = 0; i < 6; i++) begin
            expect_xfer(bo[i], bq[i], bf[i], 2);
            hold_push(bs[i], bd[i], st);
            if (st && first_stall < 0) first_stall = i;
        end
        req_valid = 1'b0;
        chk("t3_stall_after", 32'(first_stall), 32'd4);
        wait_idle(600);

        // Push and pop on the same edge with two entries queued.
        expect_xfer(16'h0030, 16'h0010, 16'h0020, 0);
        send(4'd4, 4'd5);
        expect_xfer(16'h0048, 16'h0040, 16'h0008, 2);
        send(4'd6, 4'd3);
        expect_xfer(16'h0202, 16'h0200, 16'h0002, 2);
        send(4'd9, 4'd1);
        t = 0;
        while (done_pulse !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("t6_done_seen", 32'(t < 60), 32'd1);
        chk("t6_ready_at_done", 32'(req_ready), 32'd1);
        first_stall = -1;
        expect_xfer(16'h0801, 16'h0800, 16'h0001, 2);
        hold_push(4'd11, 4'd0, st);
        if (st && first_stall < 0) first_stall = 0;
        chk("t6_ready_after_pushpop", 32'(req_ready), 32'd1);
        expect_xfer(16'hC000, 16'h8000, 16'h4000, 2);
        hold_push(4'd15, 4'd14, st);
        if (st && first_stall < 0) first_stall = 1;
        expect_xfer(16'h1100, 16'h0100, 16'h1000, 2);
        hold_push(4'd8, 4'd12, st);
        if (st && first_stall < 0) first_stall = 2;
        expect_xfer(16'h2400, 16'h2000, 16'h0400, 2);
        hold_push(4'd13, 4'd10, st);
        if (st && first_stall < 0) first_stall = 3;
        req_valid = 1'b0;
        chk("t6_stall_index", 32'(first_stall), 32'd3);
        wait_idle(600);

        // Reset in the 4th OPEN cycle with two transfers queued: nothing completes.
        send(4'd5, 4'd9);
        send(4'd2, 4'd7);
        send(4'd8, 4'd1);
        t = 0;
        while (port_open == 16'h0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("t4_open_seen", 32'(port_open), 32'h0220);
        repeat (3) @(negedge clk);
        chk("t4_still_open", 32'(port_open), 32'h0220);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_open", 32'(port_open), 32'd0);
        chk("t4_dir", 32'(port_dir), 32'd0);
        chk("t4_done", 32'(done_pulse), 32'd0);
        chk("t4_err", 32'(err_pulse), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t4_ready_after", 32'(req_ready), 32'd1);
        chk("t4_busy_after", 32'(busy), 32'd0);
        n_done = 0;
        n_busy = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done_pulse === 1'b1) n_done++;
            if (busy === 1'b1) n_busy++;
        end
        chk("t4_no_done", 32'(n_done), 32'd0);
        chk("t4_fifo_empty", 32'(n_busy), 32'd0);

        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
